// File: rtl/core_ctrl_pkg.sv
// Shared types for the multi-cycle core sequencer: phase encoding, opcodes
// and the datapath control vector layout.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_IDLE = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM      = 3'd4,
        WB       = 3'd5
    } seq_state_t;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_LDR  = 5'b00001;
    localparam logic [4:0] OP_STR  = 5'b00010;
    localparam logic [4:0] OP_BEQ  = 5'b00011;
    localparam logic [4:0] OP_ADDI = 5'b00100;
    localparam logic [4:0] OP_BNE  = 5'b00101;

    typedef struct packed {
        logic       we;
        logic       data_input_s;
        logic       data_input_on;
        logic       opb_select;
        logic       rwrite;
        logic       branch;
        logic       select_mem;
        logic       r2s;
        logic [2:0] alu_signal;
    } ctrl_vec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: latched opcode/ALU function to the raw control
// vector, plus a legal flag for the known opcode set.
module ctrl_decode
    import core_ctrl_pkg::*;
(
    input  logic [4:0] opc,
    input  logic [2:0] aluop,
    output ctrl_vec_t  vec,
    output logic       legal
);

    always_comb begin
        vec   = '0;
        legal = 1'b1;
        case (opc)
            OP_R:           vec = ctrl_vec_t'({8'b01101000, aluop});
            OP_LDR:         vec = ctrl_vec_t'(11'b00110010000);
            OP_STR:         vec = ctrl_vec_t'(11'b11010000000);
            OP_ADDI:        vec = ctrl_vec_t'(11'b01111000000);
            OP_BEQ, OP_BNE: vec = ctrl_vec_t'(11'b01101101000);
            default:        legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with opcode latch, memory
// handshake wait timer and phase-gated control outputs.
module multicycle_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] OPCODE,
    input  logic [2:0] ALUOP,
    input  logic       ZERO,
    input  logic       IMEM_READY,
    input  logic       DMEM_READY,
    output logic       IMemReq,
    output logic       DMemReq,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       WE,
    output logic       DataInputS,
    output logic       DataInputON,
    output logic       OpbSelect,
    output logic       RWrite,
    output logic       Branch,
    output logic       SelectMem,
    output logic       R2S,
    output logic [2:0] ALUSignal,
    output logic       ILLEGAL,
    output logic       MEM_ERR
);

    seq_state_t       state;
    logic [4:0]       opc_q;
    logic [2:0]       aluop_q;
    logic [TMR_W-1:0] timer;
    ctrl_vec_t        vec;
    logic             legal;
    logic             at_limit;
    logic             is_branch;
    logic             taken;

    ctrl_decode u_decode (
        .opc   (opc_q),
        .aluop (aluop_q),
        .vec   (vec),
        .legal (legal)
    );

    assign at_limit  = (timer == TMR_W'(MEM_TIMEOUT));
    assign is_branch = (opc_q == OP_BEQ) || (opc_q == OP_BNE);
    assign taken     = (opc_q == OP_BEQ) ? ZERO : !ZERO;

    // Timer is held at zero outside the two waiting phases, so every entry into
    // FETCH or MEM starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RST_IDLE;
            opc_q   <= '0;
            aluop_q <= '0;
            timer   <= '0;
        end else begin
            timer <= '0;
            case (state)
                RST_IDLE: state <= FETCH;
                FETCH: begin
                    if (IMEM_READY) begin
                        opc_q   <= OPCODE;
                        aluop_q <= ALUOP;
                        state   <= DECODE;
                    end else if (!at_limit) begin
                        timer <= timer + 1'b1;
                    end
                end
                DECODE: state <= legal ? EXEC : FETCH;
                EXEC: begin
                    if (opc_q == OP_LDR || opc_q == OP_STR) state <= MEM;
                    else if (is_branch)                     state <= FETCH;
                    else                                    state <= WB;
                end
                MEM: begin
                    if (DMEM_READY)     state <= (opc_q == OP_STR) ? FETCH : WB;
                    else if (at_limit)  state <= FETCH;
                    else                timer <= timer + 1'b1;
                end
                WB:      state <= FETCH;
                default: state <= RST_IDLE;
            endcase
        end
    end

    always_comb begin
        IMemReq     = 1'b0;
        DMemReq     = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        WE          = 1'b0;
        DataInputS  = 1'b0;
        DataInputON = 1'b0;
        OpbSelect   = 1'b0;
        RWrite      = 1'b0;
        Branch      = 1'b0;
        SelectMem   = 1'b0;
        R2S         = 1'b0;
        ALUSignal   = 3'b000;
        ILLEGAL     = 1'b0;
        MEM_ERR     = 1'b0;
        if (rst_n) begin
            if (state == EXEC || state == MEM || state == WB) begin
                DataInputS  = vec.data_input_s;
                DataInputON = vec.data_input_on;
                OpbSelect   = vec.opb_select;
                SelectMem   = vec.select_mem;
                R2S         = vec.r2s;
                ALUSignal   = vec.alu_signal;
            end
            case (state)
                FETCH: begin
                    IMemReq = 1'b1;
                    if (IMEM_READY) begin
                        IRWrite = 1'b1;
                    end else if (at_limit) begin
                        MEM_ERR = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                DECODE: begin
                    ILLEGAL = !legal;
                    PCWrite = !legal;
                end
                EXEC: begin
                    PCWrite = is_branch;
                    Branch  = is_branch && taken;
                end
                MEM: begin
                    DMemReq = 1'b1;
                    if (DMEM_READY) begin
                        WE      = vec.we;
                        PCWrite = (opc_q == OP_STR);
                    end else if (at_limit) begin
                        MEM_ERR = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                WB: begin
                    RWrite  = 1'b1;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle
// trace of inputs and outputs from the phase rules, then replayed on the DUT.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] OPCODE;
    logic [2:0] ALUOP;
    logic       ZERO, IMEM_READY, DMEM_READY;
    logic       IMemReq, DMemReq, IRWrite, PCWrite, WE, DataInputS, DataInputON;
    logic       OpbSelect, RWrite, Branch, SelectMem, R2S, ILLEGAL, MEM_ERR;
    logic [2:0] ALUSignal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(15), .TMR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .ALUOP(ALUOP), .ZERO(ZERO),
        .IMEM_READY(IMEM_READY), .DMEM_READY(DMEM_READY),
        .IMemReq(IMemReq), .DMemReq(DMemReq), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .WE(WE), .DataInputS(DataInputS), .DataInputON(DataInputON),
        .OpbSelect(OpbSelect), .RWrite(RWrite), .Branch(Branch),
        .SelectMem(SelectMem), .R2S(R2S), .ALUSignal(ALUSignal),
        .ILLEGAL(ILLEGAL), .MEM_ERR(MEM_ERR)
    );

    // {IMemReq,DMemReq,IRWrite,PCWrite,WE,DIS,DION,Opb,RWrite,Branch,SelMem,R2S,ALU[2:0],ILLEGAL,MEM_ERR}
    typedef struct packed {
        logic        imem;
        logic        dmem;
        logic        zero;
        logic [4:0]  opc;
        logic [2:0]  alu;
        logic [2:0]  ph;
        logic [16:0] exp;
    } step_t;

    step_t q[$];

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {IMemReq, DMemReq, IRWrite, PCWrite, WE, DataInputS, DataInputON, OpbSelect,
                RWrite, Branch, SelectMem, R2S, ALUSignal, ILLEGAL, MEM_ERR};
    endfunction

    function automatic logic [16:0] mk(input logic imr, dmr, irw, pcw,
                                       input logic [10:0] v, input logic ill, merr);
        return {imr, dmr, irw, pcw, v, ill, merr};
    endfunction

    function automatic logic [10:0] vbase(input logic [4:0] opc, input logic [2:0] alu);
        case (opc)
            5'd0:       return {8'b01101000, alu};
            5'd1:       return 11'b00110010000;
            5'd2:       return 11'b11010000000;
            5'd4:       return 11'b01111000000;
            5'd3, 5'd5: return 11'b01101101000;
            default:    return 11'b0;
        endcase
    endfunction

    function automatic string ph_name(input logic [2:0] ph);
        case (ph)
            3'd1:    return "fetch";
            3'd2:    return "decode";
            3'd3:    return "exec";
            3'd4:    return "mem";
            default: return "wb";
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic [4:0] ro();
        return 5'($urandom_range(31, 0));
    endfunction

    task automatic push(input logic im, dm, z, input logic [4:0] o, input logic [2:0] ph,
                        input logic [16:0] e);
        step_t s;
        s.imem = im; s.dmem = dm; s.zero = z; s.opc = o;
        s.alu  = 3'($urandom_range(7, 0)); s.ph = ph; s.exp = e;
        q.push_back(s);
    endtask

    // iw/dw: number of not-ready cycles before the ack; 16 or more means no ack.
    task automatic build(input logic [4:0] opc, input logic [2:0] alu, input logic zero,
                         input int iw, input int dw);
        bit done = 0;
        bit legal = (opc <= 5'd5);
        bit br = (opc == 5'd3) || (opc == 5'd5);
        bit st = (opc == 5'd2);
        logic [10:0] m = vbase(opc, alu) & ~11'b10001100000;
        logic taken = (opc == 5'd3) ? zero : !zero;
        step_t s;
        for (int k = 0; k < 16 && !done; k++) begin
            if (k == iw) begin
                s.imem = 1; s.dmem = rb(); s.zero = rb(); s.opc = opc; s.alu = alu;
                s.ph = 3'd1; s.exp = mk(1, 0, 1, 0, 0, 0, 0);
                q.push_back(s);
                done = 1;
            end else if (k == 15) begin
                push(0, rb(), rb(), ro(), 3'd1, mk(1, 0, 0, 1, 0, 0, 1));
            end else begin
                push(0, rb(), rb(), ro(), 3'd1, mk(1, 0, 0, 0, 0, 0, 0));
            end
        end
        if (!done) return;
        push(rb(), rb(), rb(), ro(), 3'd2, legal ? 17'd0 : mk(0, 0, 0, 1, 0, 1, 0));
        if (!legal) return;
        if (br) begin
            push(rb(), rb(), zero, ro(), 3'd3, mk(0, 0, 0, 1, m | (11'(taken) << 5), 0, 0));
            return;
        end
        push(rb(), rb(), zero, ro(), 3'd3, mk(0, 0, 0, 0, m, 0, 0));
        if (opc == 5'd1 || st) begin
            done = 0;
            for (int k = 0; k < 16 && !done; k++) begin
                if (k == dw) begin
                    push(rb(), 1, rb(), ro(), 3'd4,
                         mk(0, 1, 0, st, m | (st ? 11'b10000000000 : 11'b0), 0, 0));
                    done = 1;
                end else if (k == 15) begin
                    push(rb(), 0, rb(), ro(), 3'd4, mk(0, 1, 0, 1, m, 0, 1));
                end else begin
                    push(rb(), 0, rb(), ro(), 3'd4, mk(0, 1, 0, 0, m, 0, 0));
                end
            end
            if (!done || st) return;
        end
        push(rb(), rb(), rb(), ro(), 3'd5, mk(0, 0, 0, 1, m | 11'b00001000000, 0, 0));
    endtask

    task automatic play(input int limit);
        int n = 0;
        while (q.size() > 0 && n < limit) begin
            step_t s = q.pop_front();
            @(negedge clk);
            IMEM_READY = s.imem; DMEM_READY = s.dmem; ZERO = s.zero;
            OPCODE = s.opc; ALUOP = s.alu;
            #2 chk(ph_name(s.ph), outs(), s.exp);
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset(input int low_cycles);
        for (int i = 0; i < low_cycles; i++) begin
            @(negedge clk);
            rst_n = 0; IMEM_READY = rb(); DMEM_READY = rb(); ZERO = rb(); OPCODE = ro();
            #2 chk("rst_low", outs(), 17'd0);
        end
        @(negedge clk);
        rst_n = 1; IMEM_READY = rb(); DMEM_READY = rb();
        #2 chk("rst_idle", outs(), 17'd0);
    endtask

    function automatic int rwait();
        int r = $urandom_range(9, 0);
        if (r < 6) return 0;
        if (r < 9) return $urandom_range(4, 1);
        return $urandom_range(16, 14);
    endfunction

    initial begin
        rst_n = 0; OPCODE = 0; ALUOP = 0; ZERO = 0; IMEM_READY = 0; DMEM_READY = 0;
        do_reset(2);

        build(5'd0, 3'b010, 0, 0, 0);  play(1000);
        build(5'd1, 3'b000, 0, 0, 3);  play(1000);
        build(5'd3, 3'b000, 1, 0, 0);  play(1000);
        build(5'd5, 3'b000, 1, 0, 0);  play(1000);
        build(5'd2, 3'b000, 0, 0, 20); play(1000);
        build(5'd2, 3'b000, 0, 0, 0);  play(1000);
        build(5'd31, 3'b000, 0, 0, 0); play(1000);
        build(5'd4, 3'b101, 0, 15, 15); play(1000);
        build(5'd2, 3'b000, 0, 0, 20); play(5);
        do_reset(1);
        build(5'd0, 3'b111, 0, 16, 0); play(1000);

        for (int i = 0; i < 200; i++) begin
            int r = $urandom_range(7, 0);
            logic [4:0] opc = (r == 6) ? 5'($urandom_range(31, 6)) : 5'($urandom_range(5, 0));
            build(opc, 3'($urandom_range(7, 0)), rb(), rwait(), rwait());
            if ($urandom_range(24, 0) == 0) begin
                play($urandom_range(6, 1));
                do_reset($urandom_range(2, 1));
            end else begin
                play(1000);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
